// File: rtl/regfile_seq_ctrl_if.sv
// Bundle between the instruction source / RegisterFile side (master) and the
// sequencer (slave).
interface regfile_seq_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   // valid/ready: an instruction transfers on a rising edge where InValid && InReady;
   // the source may hold or change InValid/Instruction freely while InReady is low.
   logic              InValid;
   logic              InReady;
   logic [31:0]       Instruction;
   logic [ADDR_W-1:0] ReadReg1;
   logic [ADDR_W-1:0] ReadReg2;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic              RegWrite;
   logic [DATA_W-1:0] ReadData1;
   logic [DATA_W-1:0] ReadData2;
   logic              Busy;
   logic              Done;
   logic              Err;

   modport master (
      output InValid, Instruction, ReadData1, ReadData2,
      input  InReady, ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, Busy, Done, Err
   );

   modport slave (
      input  InValid, Instruction, ReadData1, ReadData2,
      output InReady, ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, Busy, Done, Err
   );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle R-type sequencer: IDLE -> READ -> EXEC -> WRITE -> DONE against a
// register file with registered reads and writes.
module regfile_seq_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   regfile_seq_ctrl_if.slave   bus,
   output logic [2:0]          StateDbg
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   state_t            state_q, state_d;
   logic [5:0]        op_q, op_d;
   logic [5:0]        funct_q, funct_d;
   logic [ADDR_W-1:0] read_reg1_q, read_reg1_d;
   logic [ADDR_W-1:0] read_reg2_q, read_reg2_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              reg_write_q, reg_write_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] alu_res;
   logic              op_ok;
   logic              unused_fields;

   // Register-field bits above ADDR_W and shamt carry no meaning here.
   assign unused_fields = ^{bus.Instruction[25:21+ADDR_W], bus.Instruction[20:16+ADDR_W],
                            bus.Instruction[15:11+ADDR_W], bus.Instruction[10:6]};

   always_comb begin
      op_ok   = (op_q == 6'd0);
      alu_res = '0;
      case (funct_q)
         F_ADD:   alu_res = bus.ReadData1 + bus.ReadData2;
         F_SUB:   alu_res = bus.ReadData1 - bus.ReadData2;
         F_AND:   alu_res = bus.ReadData1 & bus.ReadData2;
         F_OR:    alu_res = bus.ReadData1 | bus.ReadData2;
         F_SLT:   alu_res = {{(DATA_W-1){1'b0}},
                             ($signed(bus.ReadData1) < $signed(bus.ReadData2))};
         default: op_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      funct_d      = funct_q;
      read_reg1_d  = read_reg1_q;
      read_reg2_d  = read_reg2_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      reg_write_d  = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.InValid) begin
               op_d        = bus.Instruction[31:26];
               funct_d     = bus.Instruction[5:0];
               read_reg1_d = bus.Instruction[21 +: ADDR_W];
               read_reg2_d = bus.Instruction[16 +: ADDR_W];
               write_reg_d = bus.Instruction[11 +: ADDR_W];
               state_d     = S_READ;
            end
         end
         S_READ: state_d = S_EXEC;
         // Register file data is valid only in this state.
         S_EXEC: begin
            if (op_ok) begin
               write_data_d = alu_res;
               reg_write_d  = 1'b1;
               state_d      = S_WRITE;
            end else begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_WRITE: begin
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         funct_q      <= '0;
         read_reg1_q  <= '0;
         read_reg2_q  <= '0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         reg_write_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         funct_q      <= funct_d;
         read_reg1_q  <= read_reg1_d;
         read_reg2_q  <= read_reg2_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         reg_write_q  <= reg_write_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign bus.InReady   = (state_q == S_IDLE);
   assign bus.Busy      = (state_q != S_IDLE);
   assign bus.ReadReg1  = read_reg1_q;
   assign bus.ReadReg2  = read_reg2_q;
   assign bus.WriteReg  = write_reg_q;
   assign bus.WriteData = write_data_q;
   assign bus.RegWrite  = reg_write_q;
   assign bus.Done      = done_q;
   assign bus.Err       = err_q;
   assign StateDbg      = state_q;
endmodule
